// File: rtl/dma_rd_sched.sv
// dma_rd_sched: reads a job of fixed-length bursts from DRAM and scatters the
// beats round-robin across NUM_BANK BRAM banks (burst n -> bank n mod NUM_BANK).
// Optional busy-cycle counter enabled by defining DMA_RD_SCHED_PERF_EN.
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | launch one read burst
// WAIT  | collect beats until i_read_done
// NEXT  | pick next burst, or finish; stalls while i_hold
// FIN   | emit o_done, back to IDLE
module dma_rd_sched #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int NUM_BANK     = 16,
    parameter int BURST_LEN    = 16,
    parameter int BANK_AW      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [AXI_WIDTH_AD-1:0] i_base_addr,
    input  logic [8:0]              i_num_blk,
    input  logic                    i_hold,
    output logic                    o_ctrl_read,
    output logic [AXI_WIDTH_AD-1:0] o_read_addr,
    input  logic                    i_read_data_vld,
    input  logic [AXI_WIDTH_DA-1:0] i_read_data,
    input  logic                    i_read_done,
    output logic [NUM_BANK-1:0]     o_bram_we,
    output logic [BANK_AW-1:0]      o_bram_addr,
    output logic [AXI_WIDTH_DA-1:0] o_bram_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [31:0]             o_perf_cycles
);

    localparam int BEAT_W     = $clog2(BURST_LEN + 1);
    localparam int BANK_SEL_W = $clog2(NUM_BANK);
    localparam int STRIDE     = BURST_LEN * (AXI_WIDTH_DA / 8);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_FIN} state_t;

    state_t                  state_q, state_d;
    logic [AXI_WIDTH_AD-1:0] base_q, base_d;
    logic [8:0]              num_blk_q, num_blk_d;
    logic [8:0]              blk_idx_q, blk_idx_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    err_q, err_d;
    logic                    ctrl_read_q, ctrl_read_d;
    logic [AXI_WIDTH_AD-1:0] read_addr_q, read_addr_d;
    logic [NUM_BANK-1:0]     bram_we_q, bram_we_d;
    logic [BANK_AW-1:0]      bram_addr_q, bram_addr_d;
    logic [AXI_WIDTH_DA-1:0] bram_data_q, bram_data_d;
    logic                    done_q, done_d;
    logic [BEAT_W-1:0]       beat_total;
    logic [31:0]             word_addr;

    // Next-state, datapath updates and registered-output values
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_blk_d   = num_blk_q;
        blk_idx_d   = blk_idx_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        ctrl_read_d = 1'b0;
        read_addr_d = read_addr_q;
        bram_we_d   = '0;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;
        done_d      = 1'b0;
        beat_total  = beat_cnt_q;
        word_addr   = 32'(blk_idx_q >> BANK_SEL_W) * 32'(BURST_LEN) + 32'(beat_cnt_q);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d     = i_base_addr;
                    num_blk_d  = i_num_blk;
                    blk_idx_d  = '0;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = (i_num_blk == 9'd0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                ctrl_read_d = 1'b1;
                read_addr_d = base_q + AXI_WIDTH_AD'(blk_idx_q) * AXI_WIDTH_AD'(STRIDE);
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (i_read_data_vld) begin
                    if (beat_cnt_q < BEAT_W'(BURST_LEN)) begin
                        bram_we_d   = NUM_BANK'(1) << blk_idx_q[BANK_SEL_W-1:0];
                        bram_addr_d = word_addr[BANK_AW-1:0];
                        bram_data_d = i_read_data;
                        beat_total  = beat_cnt_q + BEAT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                beat_cnt_d = beat_total;
                // a beat arriving with done is already folded into beat_total
                if (i_read_done) begin
                    if (beat_total != BEAT_W'(BURST_LEN)) begin
                        err_d = 1'b1;
                    end
                    blk_idx_d  = blk_idx_q + 9'd1;
                    beat_cnt_d = '0;
                    state_d    = S_NEXT;
                end
            end
            S_NEXT: begin
                if (blk_idx_q == num_blk_q) begin
                    state_d = S_FIN;
                end else if (!i_hold) begin
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_blk_q   <= '0;
            blk_idx_q   <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            ctrl_read_q <= 1'b0;
            read_addr_q <= '0;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_blk_q   <= num_blk_d;
            blk_idx_q   <= blk_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            ctrl_read_q <= ctrl_read_d;
            read_addr_q <= read_addr_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
            done_q      <= done_d;
        end
    end

    assign o_ctrl_read = ctrl_read_q;
    assign o_read_addr = read_addr_q;
    assign o_bram_we   = bram_we_q;
    assign o_bram_addr = bram_addr_q;
    assign o_bram_data = bram_data_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;

`ifdef DMA_RD_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle count: cleared on an accepted start, saturating
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE && i_start) begin
            perf_d = '0;
        end else if (state_q != S_IDLE && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Busy-cycle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign o_perf_cycles = perf_q;
`else
    assign o_perf_cycles = '0;
`endif

endmodule

// File: doc/dma_rd_sched.md
DMA_RD_SCHED -- requirements
Module: dma_rd_sched

Interface
REQ-001 SHALL have parameter AXI_WIDTH_AD, default 32, meaning DRAM byte-address width.
REQ-002 SHALL have parameter AXI_WIDTH_DA, default 32, meaning read-data width.
REQ-003 SHALL have parameter NUM_BANK, default 16, meaning BRAM bank count (power of 2).
REQ-004 SHALL have parameter BURST_LEN, default 16, meaning beats per AXI read burst.
REQ-005 SHALL have parameter BANK_AW, default 8, meaning per-bank word-address width.
REQ-006 SHALL have ports in this order and with these directions, widths and meanings:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle job start pulse.
- i_base_addr  in  AXI_WIDTH_AD  job DRAM base byte address.
- i_num_blk  in  9  bursts in job, 0..256.
- i_hold  in  1  compute back-pressure; blocks new burst issue.
- o_ctrl_read  out  1  one-cycle start pulse to the read DMA.
- o_read_addr  out  AXI_WIDTH_AD  burst start address, held stable through the burst.
- i_read_data_vld  in  1  read beat valid.
- i_read_data  in  AXI_WIDTH_DA  read beat data.
- i_read_done  in  1  one-cycle burst-complete pulse.
- o_bram_we  out  NUM_BANK  one-hot bank write enable.
- o_bram_addr  out  BANK_AW  bank word address.
- o_bram_data  out  AXI_WIDTH_DA  bank write data.
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle job-complete pulse.
- o_err  out  1  sticky beat-count error.
- o_perf_cycles  out  32  busy-cycle counter.

Function
REQ-007 SHALL implement the states IDLE, ISSUE, WAIT, NEXT and FIN.
REQ-008 IDLE: on i_start, SHALL latch i_base_addr and i_num_blk, clear blk_idx, beat_cnt and o_err, then go to ISSUE; if i_num_blk==0, SHALL go to FIN instead.
REQ-009 ISSUE: SHALL assert o_ctrl_read for exactly one cycle with o_read_addr = base + blk_idx*BURST_LEN*(AXI_WIDTH_DA/8), then go to WAIT.
REQ-010 o_read_addr SHALL be computed modulo 2^AXI_WIDTH_AD, with wrap-around and no error.
REQ-011 WAIT: each i_read_data_vld beat SHALL be written to bank (blk_idx mod NUM_BANK) at word (blk_idx/NUM_BANK)*BURST_LEN + beat_cnt, then beat_cnt SHALL increment.
REQ-012 The bank write SHALL be registered: o_bram_we, o_bram_addr and o_bram_data SHALL be valid exactly 1 cycle after the beat.
REQ-013 o_bram_we SHALL be all-zero in every cycle that has no registered beat.
REQ-014 In WAIT, beats beyond BURST_LEN SHALL be dropped (no write) and SHALL set o_err.
REQ-015 On i_read_done in WAIT, beat_cnt != BURST_LEN SHALL set o_err, then blk_idx SHALL increment, beat_cnt SHALL clear, and the FSM SHALL go to NEXT.
REQ-016 If i_read_data_vld and i_read_done occur in the same cycle, the beat SHALL be counted before the count check.
REQ-017 NEXT: if blk_idx==num_blk, SHALL go to FIN; else if i_hold==0, SHALL go to ISSUE; else SHALL stay in NEXT.
REQ-018 FIN: SHALL pulse o_done for one cycle and return to IDLE.
REQ-019 o_busy SHALL be 1 in every state except IDLE.
REQ-020 i_start outside IDLE SHALL be ignored.
REQ-021 i_read_data_vld and i_read_done outside WAIT SHALL be ignored.
REQ-022 o_err SHALL hold its value until the next accepted i_start or rst.

Reset
REQ-023 With rst high at a clk edge, the FSM SHALL enter IDLE and all outputs SHALL be 0, including o_read_addr and o_perf_cycles.
REQ-024 rst high mid-job SHALL abandon the job with no o_done pulse, and no bank write SHALL occur in the following cycle.

Configuration
REQ-025 With macro DMA_RD_SCHED_PERF_EN defined, o_perf_cycles SHALL clear on an accepted i_start and SHALL increment, saturating at 2^32-1, each cycle o_busy==1.
REQ-026 Without DMA_RD_SCHED_PERF_EN, o_perf_cycles SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-027 SHALL cover: base 0x8000_0000, num_blk=2, 16 beats per burst, i_hold=0 -> read addresses 0x8000_0000 and 0x8000_0040; bank0 addr 0..15 and bank1 addr 0..15 written; one o_done; o_err=0.
REQ-028 SHALL cover: num_blk=17 -> burst 16 writes bank0 addr 16..31, o_read_addr=0x8000_0400.
REQ-029 SHALL cover: num_blk=0 -> o_done 2 cycles after i_start, no o_ctrl_read.
REQ-030 SHALL cover: 15 beats then i_read_done -> o_err=1 that persists after o_done; next accepted i_start clears it.
REQ-031 SHALL cover: i_hold=1 for 10 cycles in NEXT -> no o_ctrl_read until i_hold falls, then o_ctrl_read on the 2nd cycle after the fall.
REQ-032 SHALL cover: rst asserted during WAIT -> IDLE next cycle, o_bram_we=0, o_done never pulses; with PERF_EN, num_blk=1 and 16 contiguous beats -> o_perf_cycles equals busy-cycle count.
